alu_share_arbiter: RTL and testbench

Two-requester round-robin arbiter that time-shares one `alu_top` datapath instance between the main execute stage (port 0) and a secondary client such as address-generation or a multi-cycle helper (port 1). Each port uses a valid/ready request handshake. Each granted operation is evaluated by the embedded ALU in the grant cycle and captured into a single registered response slot, tagged with the requester ID, one cycle later. The block also keeps saturating per-port grant counters for performance observation.

---
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 tb/tb_alu_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Results land in a single registered response slot tagged with the requester id.

module alu_top (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  alu_control,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   output logic [31:0] result
);
   logic lt;

   always_comb begin
      lt = funct3[0] ? (a < b) : ($signed(a) < $signed(b));
      case (alu_control)
         3'b000:  result = a + b;
         3'b001:  result = a - b;
         3'b010:  result = a & b;
         3'b011:  result = a | b;
         3'b100:  result = a ^ b;
         3'b101:  result = {31'b0, lt};
         default: begin
            // funct3[2] clear selects left shift; otherwise funct7_5 picks arithmetic right
            if (!funct3[2])    result = a << b[4:0];
            else if (funct7_5) result = $unsigned($signed(a) >>> b[4:0]);
            else               result = a >> b[4:0];
         end
      endcase
   end
endmodule

module alu_share_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_A,
   input  logic [31:0]      req0_B,
   input  logic [2:0]       req0_ALUControl,
   input  logic [2:0]       req0_funct3,
   input  logic             req0_funct7_5,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_A,
   input  logic [31:0]      req1_B,
   input  logic [2:0]       req1_ALUControl,
   input  logic [2:0]       req1_funct3,
   input  logic             req1_funct7_5,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);
   logic        prio;
   logic        grant_id;
   logic        slot_free;
   logic        accept;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_ctl;
   logic [2:0]  alu_f3;
   logic        alu_f7;
   logic [31:0] alu_result;

   always_comb begin
      if (req0_valid && req1_valid) grant_id = prio;
      else                          grant_id = req1_valid;
   end

   assign slot_free  = !rsp_valid || rsp_ready;
   assign accept     = !rst && slot_free && (req0_valid || req1_valid);
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept && grant_id;

   assign alu_a   = grant_id ? req1_A          : req0_A;
   assign alu_b   = grant_id ? req1_B          : req0_B;
   assign alu_ctl = grant_id ? req1_ALUControl : req0_ALUControl;
   assign alu_f3  = grant_id ? req1_funct3     : req0_funct3;
   assign alu_f7  = grant_id ? req1_funct7_5   : req0_funct7_5;

   alu_top u_alu (
      .a           (alu_a),
      .b           (alu_b),
      .alu_control (alu_ctl),
      .funct3      (alu_f3),
      .funct7_5    (alu_f7),
      .result      (alu_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         prio       <= 1'b0;
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= grant_id;
         rsp_result <= alu_result;
         prio       <= ~grant_id;
         if (!grant_id) begin
            if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         end else begin
            if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
         end
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: queue-based requester/response model, directed
// scenarios with literal expectations, then a randomized run.

module tb_alu_share_arbiter;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  ctl;
      logic [2:0]  f3;
      logic        f7;
   } op_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready, s_req0_ready, s_req1_ready;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic [2:0]  req0_ALUControl, req0_funct3, req1_ALUControl, req1_funct3;
   logic        req0_funct7_5, req1_funct7_5;
   logic        rsp_valid, rsp_ready, rsp_id, s_rsp_valid, s_rsp_id;
   logic [31:0] rsp_result, s_rsp_result;
   logic [15:0] grant_cnt0, grant_cnt1;
   logic [3:0]  s_grant_cnt0, s_grant_cnt1;

   always #5 clk = ~clk;

   alu_share_arbiter #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
      .req0_ALUControl(req0_ALUControl), .req0_funct3(req0_funct3), .req0_funct7_5(req0_funct7_5),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
      .req1_ALUControl(req1_ALUControl), .req1_funct3(req1_funct3), .req1_funct7_5(req1_funct7_5),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
   );

   alu_share_arbiter #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_A(req0_A), .req0_B(req0_B),
      .req0_ALUControl(req0_ALUControl), .req0_funct3(req0_funct3), .req0_funct7_5(req0_funct7_5),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_A(req1_A), .req1_B(req1_B),
      .req1_ALUControl(req1_ALUControl), .req1_funct3(req1_funct3), .req1_funct7_5(req1_funct7_5),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result),
      .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
   );

   int n_chk = 0;
   int n_fail = 0;

   op_t q0[$];
   op_t q1[$];
   bit  hold0 = 0, hold1 = 0;
   bit  rand_mode = 0;
   bit  rr_fixed = 1;
   logic last_r0, last_r1;

   // model state: response slot, whose turn it is on a tie, accepted counts
   bit          m_valid;
   bit          m_id;
   logic [31:0] m_res;
   bit          m_turn;
   int          c0, c1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] alu_ref(input op_t o);
      int sh;
      sh = int'(o.b[4:0]);
      case (o.ctl)
         3'd0: return o.a + o.b;
         3'd1: return o.a - o.b;
         3'd2: return o.a & o.b;
         3'd3: return o.a | o.b;
         3'd4: return o.a ^ o.b;
         3'd5: begin
            if (o.f3[0]) return (o.a < o.b) ? 32'd1 : 32'd0;
            return ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
         end
         default: begin
            if (!o.f3[2]) return o.a << sh;
            if (o.f7)     return $unsigned($signed(o.a) >>> sh);
            return o.a >> sh;
         end
      endcase
   endfunction

   function automatic op_t mk(input logic [31:0] a, b, input logic [2:0] ctl, f3, input logic f7);
      op_t o;
      o.a = a; o.b = b; o.ctl = ctl; o.f3 = f3; o.f7 = f7;
      return o;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'(int'($urandom_range(40)));
         default: return $urandom;
      endcase
   endfunction

   function automatic op_t rand_op();
      return mk(rand_word(), rand_word(), 3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)));
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // One clock cycle: drive requesters, check everything at negedge, advance model at posedge.
   task automatic step();
      bit v0, v1, g, acc;
      op_t o;
      v0 = (q0.size() > 0) && (hold0 || !rand_mode || $urandom_range(3) != 0);
      v1 = (q1.size() > 0) && (hold1 || !rand_mode || $urandom_range(3) != 0);
      o = v0 ? q0[0] : rand_op();
      req0_valid = v0; req0_A = o.a; req0_B = o.b; req0_ALUControl = o.ctl; req0_funct3 = o.f3; req0_funct7_5 = o.f7;
      o = v1 ? q1[0] : rand_op();
      req1_valid = v1; req1_A = o.a; req1_B = o.b; req1_ALUControl = o.ctl; req1_funct3 = o.f3; req1_funct7_5 = o.f7;
      rsp_ready = rand_mode ? ($urandom_range(3) != 0) : rr_fixed;

      @(negedge clk);
      g   = (v0 && v1) ? m_turn : v1;
      acc = (v0 || v1) && (!m_valid || rsp_ready);
      last_r0 = req0_ready;
      last_r1 = req1_ready;
      chk("req0_ready", 32'(req0_ready), 32'(acc && !g));
      chk("req1_ready", 32'(req1_ready), 32'(acc && g));
      chk("sat_req0_ready", 32'(s_req0_ready), 32'(acc && !g));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
         chk("rsp_result", rsp_result, m_res);
      end
      chk("grant_cnt0", 32'(grant_cnt0), 32'(sat(c0, 65535)));
      chk("grant_cnt1", 32'(grant_cnt1), 32'(sat(c1, 65535)));
      chk("sat_grant_cnt0", 32'(s_grant_cnt0), 32'(sat(c0, 15)));
      chk("sat_grant_cnt1", 32'(s_grant_cnt1), 32'(sat(c1, 15)));

      @(posedge clk);
      if (m_valid && rsp_ready) m_valid = 0;
      if (acc) begin
         o = g ? q1.pop_front() : q0.pop_front();
         m_res = alu_ref(o);
         m_id = g;
         m_valid = 1;
         m_turn = !g;
         if (g) c1++; else c0++;
      end
      hold0 = v0 && !(acc && !g);
      hold1 = v1 && !(acc && g);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      m_valid = 0; m_turn = 0; c0 = 0; c1 = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
      chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      req0_A = 0; req0_B = 0; req0_ALUControl = 0; req0_funct3 = 0; req0_funct7_5 = 0;
      req1_A = 0; req1_B = 0; req1_ALUControl = 0; req1_funct3 = 0; req1_funct7_5 = 0;
      repeat (2) @(posedge clk);
      apply_reset();

      // single add on port 0
      q0.push_back(mk(32'd5, 32'd3, 3'd0, 3'd0, 1'b0));
      step();
      chk("single_ready0", 32'(last_r0), 32'd1);
      chk("single_result", rsp_result, 32'd8);
      chk("single_id", 32'(rsp_id), 32'd0);
      chk("single_cnt0", 32'(grant_cnt0), 32'd1);

      // port 1 sub / signed / unsigned compare
      q1.push_back(mk(32'd3, 32'd5, 3'd1, 3'd0, 1'b0));
      step();
      chk("sub_result", rsp_result, 32'hFFFF_FFFE);
      chk("sub_id", 32'(rsp_id), 32'd1);
      q1.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'd5, 3'b010, 1'b0));
      step();
      chk("slt_result", rsp_result, 32'd1);
      q1.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'd5, 3'b011, 1'b0));
      step();
      chk("sltu_result", rsp_result, 32'd0);
      step();

      // contention
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(rand_op());
         q1.push_back(rand_op());
      end
      for (int i = 0; i < 6; i++) begin
         step();
         chk("contend_id", 32'(rsp_id), 32'(i % 2));
      end
      chk("contend_cnt0", 32'(grant_cnt0), 32'd3);
      chk("contend_cnt1", 32'(grant_cnt1), 32'd3);
      step();

      // backpressure
      apply_reset();
      q0.push_back(mk(32'd10, 32'd20, 3'd0, 3'd0, 1'b0));
      q0.push_back(rand_op()); q0.push_back(rand_op());
      for (int i = 0; i < 3; i++) q1.push_back(rand_op());
      rr_fixed = 1;
      step();
      rr_fixed = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_ready0", 32'(last_r0), 32'd0);
         chk("bp_ready1", 32'(last_r1), 32'd0);
         chk("bp_result", rsp_result, 32'd30);
         chk("bp_cnt0", 32'(grant_cnt0), 32'd1);
      end
      rr_fixed = 1;
      step();
      chk("bp_release_ready1", 32'(last_r1), 32'd1);
      chk("bp_release_id", 32'(rsp_id), 32'd1);

      // reset mid-stream, with a response pending and both ports valid
      req0_valid = 1; req1_valid = 1;
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
      apply_reset();
      step();
      chk("post_rst_ready0", 32'(last_r0), 32'd1);
      for (int i = 0; i < 8; i++) step();

      // saturation of the 4-bit counters
      apply_reset();
      for (int i = 0; i < 20; i++) q0.push_back(rand_op());
      for (int i = 0; i < 20; i++) step();
      chk("sat_cnt0_final", 32'(s_grant_cnt0), 32'd15);
      chk("sat_cnt1_final", 32'(s_grant_cnt1), 32'd0);
      chk("wide_cnt0_final", 32'(grant_cnt0), 32'd20);
      step();

      // randomized traffic
      rand_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if (q0.size() < 3 && $urandom_range(2) != 0) q0.push_back(rand_op());
         if (q1.size() < 3 && $urandom_range(2) != 0) q1.push_back(rand_op());
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
